// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller for the 64-bit RISC-V core: sequences each instruction through
// fetch/decode/execute/memory/writeback over the shared datapath, advancing only on step_en ticks.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_en,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    funct7_b5,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic                    adr_src,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    pc_src,
    output logic                    reg_we,
    output logic                    result_src,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [2:0]              alu_ctrl,
    output logic [3:0]              state,
    output logic                    halted,
    output logic                    illegal,
    output logic                    timeout,
    output logic [RETIRE_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_HALT      = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    alu_ctrl_t         alu_op, exec_op;
    logic [WAIT_W-1:0] wait_cnt;
    logic              adv, at_limit, exec_ok;
    logic              waiting, do_retire, set_illegal, set_timeout;

    // Strobes are suppressed while reset is asserted so a dropped access never commits.
    assign adv      = step_en & rst_n;
    assign at_limit = (wait_cnt == WAIT_LIMIT);
    assign state    = state_q;
    assign alu_ctrl = alu_op;

    always_comb begin
        exec_ok = 1'b1;
        exec_op = ALU_ADD;
        case ({funct3, funct7_b5})
            4'b000_0: exec_op = ALU_ADD;
            4'b000_1: exec_op = ALU_SUB;
            4'b111_0: exec_op = ALU_AND;
            4'b110_0: exec_op = ALU_OR;
            default:  exec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        reg_we      = 1'b0;
        result_src  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_op      = ALU_ADD;
        halted      = 1'b0;
        waiting     = 1'b0;
        do_retire   = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_re    = 1'b1;
                alu_src_b = 2'd1;
                waiting   = 1'b1;
                if (adv && mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (adv && at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_DECODE: begin
                if (adv) begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                        OP_ARITH:          state_d = S_EXECUTE;
                        OP_BRANCH: begin
                            if (funct3 == 3'b000) begin
                                state_d = S_BRANCH;
                            end else begin
                                set_illegal = 1'b1;
                                state_d     = S_HALT;
                            end
                        end
                        default: begin
                            set_illegal = 1'b1;
                            state_d     = S_HALT;
                        end
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (adv) state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_re  = 1'b1;
                adr_src = 1'b1;
                waiting = 1'b1;
                if (adv && mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (adv && at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_MEM_WB: begin
                reg_we     = adv;
                result_src = 1'b1;
                if (adv) begin
                    do_retire = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM_WRITE: begin
                mem_we  = 1'b1;
                adr_src = 1'b1;
                waiting = 1'b1;
                if (adv && mem_ready) begin
                    do_retire = 1'b1;
                    state_d   = S_FETCH;
                end else if (adv && at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = exec_op;
                if (adv) begin
                    if (exec_ok) begin
                        state_d = S_ALU_WB;
                    end else begin
                        set_illegal = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_ALU_WB: begin
                reg_we = adv;
                if (adv) begin
                    do_retire = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_we     = adv & zero;
                if (adv) begin
                    do_retire = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // The wait counter restarts whenever a memory-wait state is left, so it is zero on entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            retired  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else if (step_en) begin
            state_q <= state_d;
            if (waiting && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                       wait_cnt <= '0;
            if (do_retire)   retired <= retired + RETIRE_WIDTH'(1);
            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one task per scenario with hand-computed expectations.
// Small MEM_TIMEOUT and RETIRE_WIDTH make the timeout and counter-wrap corners reachable quickly.
module tb_multicycle_control_fsm;

    localparam int MEM_TIMEOUT  = 4;
    localparam int RETIRE_WIDTH = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    step_en = 1'b1;
    logic [6:0]              opcode = 7'd0;
    logic [2:0]              funct3 = 3'd0;
    logic                    funct7_b5 = 1'b0;
    logic                    zero = 1'b0;
    logic                    mem_ready = 1'b0;
    logic                    mem_re, mem_we, adr_src, ir_we, pc_we, pc_src, reg_we, result_src;
    logic                    alu_src_a, halted, illegal, timeout;
    logic [1:0]              alu_src_b;
    logic [2:0]              alu_ctrl;
    logic [3:0]              state;
    logic [RETIRE_WIDTH-1:0] retired;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] seq [0:15];

    multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .RETIRE_WIDTH(RETIRE_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .opcode(opcode), .funct3(funct3),
        .funct7_b5(funct7_b5), .zero(zero), .mem_ready(mem_ready), .mem_re(mem_re),
        .mem_we(mem_we), .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .state(state), .halted(halted), .illegal(illegal),
        .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    // Leaves the caller just after a negedge with the FSM in FETCH and rst_n released.
    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; step_en = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_ARITH;
        @(negedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        checks++; if (retired !== 4'd0) begin errors++; $display("[TB] FAIL reset_retired got %0d want 0", retired); end
        checks++; if (illegal !== 1'b0 || timeout !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b%b want 000", illegal, timeout, halted); end
        checks++; if (ir_we !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got %b%b%b want 000", ir_we, pc_we, reg_we); end
        checks++; if (mem_re !== 1'b1 || adr_src !== 1'b0 || alu_src_a !== 1'b0 || alu_src_b !== 2'd1 || alu_ctrl !== 3'b010) begin errors++; $display("[TB] FAIL fetch_levels got %b%b%b%0d%b want 1001010", mem_re, adr_src, alu_src_a, alu_src_b, alu_ctrl); end
        rst_n = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_add;
        int nwe;
        nwe = 0;
        do_reset();
        opcode = OP_ARITH; funct3 = 3'b000; funct7_b5 = 1'b0; mem_ready = 1'b1;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd6; seq[3] = 4'd7; seq[4] = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (state !== seq[i]) begin errors++; $display("[TB] FAIL add_state[%0d] got %0d want %0d", i, state, seq[i]); end
            if (reg_we) nwe++;
            if (i == 2) begin
                checks++; if (alu_ctrl !== 3'b010 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin errors++; $display("[TB] FAIL add_exec got %b/%b/%0d want 010/1/0", alu_ctrl, alu_src_a, alu_src_b); end
            end
            if (i == 3) begin
                checks++; if (result_src !== 1'b0) begin errors++; $display("[TB] FAIL add_result_src got %b want 0", result_src); end
            end
        end
        checks++; if (nwe !== 1) begin errors++; $display("[TB] FAIL add_reg_we_cycles got %0d want 1", nwe); end
        checks++; if (retired !== 4'd1) begin errors++; $display("[TB] FAIL add_retired got %0d want 1", retired); end
    endtask

    task automatic test_alu_ops;
        logic [2:0] exp_op;
        logic [3:0] exp_s;
        exp_op = 3'b000;
        do_reset();
        opcode = OP_ARITH; mem_ready = 1'b1;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd6; seq[3] = 4'd7;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (i % 4 == 0) begin
                case (i / 4)
                    0:       begin funct3 = 3'b000; funct7_b5 = 1'b1; exp_op = 3'b110; end
                    1:       begin funct3 = 3'b110; funct7_b5 = 1'b0; exp_op = 3'b001; end
                    2:       begin funct3 = 3'b111; funct7_b5 = 1'b0; exp_op = 3'b000; end
                    default: begin funct3 = 3'b001; funct7_b5 = 1'b0; end
                endcase
            end
            #1;
            exp_s = (i == 15) ? 4'd9 : seq[i % 4];
            checks++; if (state !== exp_s) begin errors++; $display("[TB] FAIL aluops_state[%0d] got %0d want %0d", i, state, exp_s); end
            if (i % 4 == 2 && i < 12) begin
                checks++; if (alu_ctrl !== exp_op) begin errors++; $display("[TB] FAIL aluops_ctrl[%0d] got %b want %b", i, alu_ctrl, exp_op); end
            end
        end
        checks++; if (illegal !== 1'b1 || halted !== 1'b1 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL aluops_halt_flags got %b%b%b want 110", illegal, halted, timeout); end
        checks++; if (retired !== 4'd3) begin errors++; $display("[TB] FAIL aluops_retired got %0d want 3", retired); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || ir_we !== 1'b0) begin errors++; $display("[TB] FAIL halt_quiet got %b%b%b want 000", mem_re, mem_we, ir_we); end
    endtask

    task automatic test_illegal_decode;
        do_reset();
        opcode = OP_IMM; mem_ready = 1'b1;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd9; seq[3] = 4'd9; seq[4] = 4'd9; seq[5] = 4'd9;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (state !== seq[i]) begin errors++; $display("[TB] FAIL illop_state[%0d] got %0d want %0d", i, state, seq[i]); end
        end
        checks++; if (illegal !== 1'b1 || retired !== 4'd0) begin errors++; $display("[TB] FAIL illop_flags got %b/%0d want 1/0", illegal, retired); end
        do_reset();
        opcode = OP_BRANCH; funct3 = 3'b001; mem_ready = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_cleared got %b want 0", illegal); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== 4'd9 || illegal !== 1'b1) begin errors++; $display("[TB] FAIL bne_illegal got %0d/%b want 9/1", state, illegal); end
    endtask

    task automatic test_load_wait;
        int nre;
        nre = 0;
        do_reset();
        opcode = OP_LOAD; mem_ready = 1'b1;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd3;
        seq[5] = 4'd3; seq[6] = 4'd3; seq[7] = 4'd4; seq[8] = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) mem_ready = 1'b0;
            if (i == 6) mem_ready = 1'b1;
            #1;
            checks++; if (state !== seq[i]) begin errors++; $display("[TB] FAIL load_state[%0d] got %0d want %0d", i, state, seq[i]); end
            if (mem_re && adr_src) nre++;
            if (i == 2) begin
                checks++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_ctrl !== 3'b010) begin errors++; $display("[TB] FAIL load_addr got %b/%0d/%b want 1/2/010", alu_src_a, alu_src_b, alu_ctrl); end
            end
            if (i == 7) begin
                checks++; if (reg_we !== 1'b1 || result_src !== 1'b1) begin errors++; $display("[TB] FAIL load_wb got %b%b want 11", reg_we, result_src); end
            end
        end
        checks++; if (nre !== 4) begin errors++; $display("[TB] FAIL load_mem_re_cycles got %0d want 4", nre); end
        checks++; if (retired !== 4'd1 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL load_retired got %0d/%b want 1/0", retired, timeout); end
    endtask

    task automatic test_branch;
        do_reset();
        opcode = OP_BRANCH; funct3 = 3'b000; zero = 1'b1; mem_ready = 1'b1;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd8; seq[3] = 4'd0; seq[4] = 4'd1; seq[5] = 4'd8; seq[6] = 4'd0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3) zero = 1'b0;
            #1;
            checks++; if (state !== seq[i]) begin errors++; $display("[TB] FAIL beq_state[%0d] got %0d want %0d", i, state, seq[i]); end
            if (i == 2) begin
                checks++; if (pc_we !== 1'b1 || pc_src !== 1'b1 || alu_ctrl !== 3'b110) begin errors++; $display("[TB] FAIL beq_taken got %b%b/%b want 11/110", pc_we, pc_src, alu_ctrl); end
            end
            if (i == 5) begin
                checks++; if (pc_we !== 1'b0 || pc_src !== 1'b1) begin errors++; $display("[TB] FAIL beq_not_taken got %b%b want 01", pc_we, pc_src); end
            end
        end
        checks++; if (retired !== 4'd2) begin errors++; $display("[TB] FAIL beq_retired got %0d want 2", retired); end
    endtask

    task automatic test_timeout;
        logic [3:0] exp_s;
        do_reset();
        opcode = OP_ARITH; mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            step_en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            mem_ready = (i == 1) ? 1'b1 : 1'b0;
            #1;
            exp_s = (i == 6) ? 4'd9 : 4'd0;
            checks++; if (state !== exp_s) begin errors++; $display("[TB] FAIL tmo_state[%0d] got %0d want %0d", i, state, exp_s); end
            if (i == 1 || i == 5) begin
                checks++; if (ir_we !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL tmo_wait[%0d] got %b%b want 00", i, ir_we, timeout); end
            end
        end
        checks++; if (timeout !== 1'b1 || halted !== 1'b1 || illegal !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("[TB] FAIL tmo_flags got %b%b%b%b want 1100", timeout, halted, illegal, mem_re); end
    endtask

    task automatic test_store_half_rate;
        do_reset();
        opcode = OP_STORE; mem_ready = 1'b1;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd1; seq[3] = 4'd2;
        seq[4] = 4'd2; seq[5] = 4'd5; seq[6] = 4'd5; seq[7] = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            step_en = (i % 2 == 0);
            #1;
            checks++; if (state !== seq[i]) begin errors++; $display("[TB] FAIL store_state[%0d] got %0d want %0d", i, state, seq[i]); end
            if (i == 0) begin
                checks++; if (ir_we !== 1'b1 || pc_we !== 1'b1) begin errors++; $display("[TB] FAIL store_fetch_strobe got %b%b want 11", ir_we, pc_we); end
            end
            if (i == 5) begin
                checks++; if (mem_we !== 1'b1 || adr_src !== 1'b1 || retired !== 4'd0) begin errors++; $display("[TB] FAIL store_frozen got %b%b/%0d want 11/0", mem_we, adr_src, retired); end
            end
        end
        checks++; if (retired !== 4'd1) begin errors++; $display("[TB] FAIL store_retired got %0d want 1", retired); end
        step_en = 1'b1;
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        opcode = OP_STORE; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) mem_ready = 1'b0;
            #1;
        end
        checks++; if (state !== 4'd5 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL midwr_before got %0d/%b want 5/1", state, mem_we); end
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (state !== 4'd0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL midwr_after got %0d/%b want 0/0", state, mem_we); end
        checks++; if (ir_we !== 1'b0 || pc_we !== 1'b0 || retired !== 4'd0) begin errors++; $display("[TB] FAIL midwr_strobes got %b%b/%0d want 00/0", ir_we, pc_we, retired); end
        rst_n = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_retire_wrap;
        do_reset();
        opcode = OP_BRANCH; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        repeat (45) @(negedge clk);
        #1;
        checks++; if (retired !== 4'd15 || state !== 4'd0) begin errors++; $display("[TB] FAIL wrap_pre got %0d/%0d want 15/0", retired, state); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (retired !== 4'd0 || state !== 4'd0) begin errors++; $display("[TB] FAIL wrap_post got %0d/%0d want 0/0", retired, state); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_illegal_decode();
        test_load_wait();
        test_branch();
        test_timeout();
        test_store_half_rate();
        test_reset_mid_write();
        test_retire_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
